// File: rtl/donut_sequencer.sv
// Raster-driven sequencer for the donut renderer: per-line setup handshake in hblank
// and a once-per-frame Minsky rotation of angles A and B committed at vblank start.
module donut_sequencer #(
  parameter int unsigned H_DISPLAY   = 1220,
  parameter int unsigned H_TOTAL     = 1525,
  parameter int unsigned V_DISPLAY   = 480,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned ROT_SHIFT_A = 5,
  parameter int unsigned ROT_SHIFT_B = 6
) (
  input  logic               clk48,
  input  logic               rst,
  input  logic        [10:0] h_count,
  input  logic        [9:0]  v_count,
  input  logic               run,
  output logic               line_req,
  output logic        [9:0]  line_y,
  input  logic               line_ack,
  output logic signed [15:0] cos_a,
  output logic signed [15:0] sin_a,
  output logic signed [15:0] cos_b,
  output logic signed [15:0] sin_b,
  output logic               rot_valid,
  output logic        [7:0]  frame_cnt,
  output logic               overrun
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ROT_A1 = 3'd1;
  localparam logic [2:0] S_ROT_A2 = 3'd2;
  localparam logic [2:0] S_ROT_B1 = 3'd3;
  localparam logic [2:0] S_ROT_B2 = 3'd4;
  localparam logic [2:0] S_LREQ   = 3'd5;

  localparam logic [10:0] H_EVT  = 11'(H_DISPLAY);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic signed [15:0] ONE_Q14 = 16'sh4000;

  logic [2:0] state;
  logic signed [15:0] ca, sa, cb, sb;
  logic signed [15:0] sb_next;
  logic [9:0] nxt_line;
  logic       line_evt;
  logic       rot_evt;

  always_comb begin
    nxt_line = (v_count == V_LAST) ? '0 : v_count + 10'd1;
    line_evt = (h_count == H_EVT) && (nxt_line < V_VIS);
    rot_evt  = (v_count == V_VIS) && (h_count == '0);
    sb_next  = sb + (cb >>> ROT_SHIFT_B);
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      state     <= S_IDLE;
      line_req  <= 1'b0;
      line_y    <= '0;
      rot_valid <= 1'b0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
      ca        <= ONE_Q14;
      sa        <= '0;
      cb        <= ONE_Q14;
      sb        <= '0;
      cos_a     <= ONE_Q14;
      sin_a     <= '0;
      cos_b     <= ONE_Q14;
      sin_b     <= '0;
    end else begin
      rot_valid <= 1'b0;
      // A visible-line event arriving while busy cannot be serviced later, so flag it.
      if (state != S_IDLE && line_evt)
        overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (rot_evt) begin
            frame_cnt <= frame_cnt + 8'd1;
            if (run)
              state <= S_ROT_A1;
          end else if (line_evt) begin
            line_y   <= nxt_line;
            line_req <= 1'b1;
            state    <= S_LREQ;
          end
        end
        S_ROT_A1: begin
          ca    <= ca - (sa >>> ROT_SHIFT_A);
          state <= S_ROT_A2;
        end
        S_ROT_A2: begin
          sa    <= sa + (ca >>> ROT_SHIFT_A);
          state <= S_ROT_B1;
        end
        S_ROT_B1: begin
          cb    <= cb - (sb >>> ROT_SHIFT_B);
          state <= S_ROT_B2;
        end
        S_ROT_B2: begin
          // Outputs are committed in the same edge that finishes sin(B).
          sb        <= sb_next;
          cos_a     <= ca;
          sin_a     <= sa;
          cos_b     <= cb;
          sin_b     <= sb_next;
          rot_valid <= 1'b1;
          state     <= S_IDLE;
        end
        S_LREQ: begin
          if (line_ack) begin
            line_req <= 1'b0;
            state    <= S_IDLE;
          end else if (h_count == H_LAST) begin
            line_req <= 1'b0;
            overrun  <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: begin
          line_req <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_donut_sequencer.sv
// Directed bench for donut_sequencer: the bench owns the raster counters and may jump them.
module tb_donut_sequencer;

  logic               clk48 = 1'b0;
  logic               rst;
  logic        [10:0] h_count;
  logic        [9:0]  v_count;
  logic               run;
  logic               line_req;
  logic        [9:0]  line_y;
  logic               line_ack;
  logic signed [15:0] cos_a, sin_a, cos_b, sin_b;
  logic               rot_valid;
  logic        [7:0]  frame_cnt;
  logic               overrun;

  int n_cmp = 0;
  int n_err = 0;

  donut_sequencer #(
    .H_DISPLAY  (1220),
    .H_TOTAL    (1525),
    .V_DISPLAY  (480),
    .V_TOTAL    (525),
    .ROT_SHIFT_A(5),
    .ROT_SHIFT_B(6)
  ) dut (
    .clk48    (clk48),
    .rst      (rst),
    .h_count  (h_count),
    .v_count  (v_count),
    .run      (run),
    .line_req (line_req),
    .line_y   (line_y),
    .line_ack (line_ack),
    .cos_a    (cos_a),
    .sin_a    (sin_a),
    .cos_b    (cos_b),
    .sin_b    (sin_b),
    .rot_valid(rot_valid),
    .frame_cnt(frame_cnt),
    .overrun  (overrun)
  );

  always #5 clk48 = ~clk48;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; afterwards h/v describe the new cycle and outputs reflect the edge just taken.
  task automatic tick();
    @(posedge clk48);
    #1;
    if (h_count == 11'd1524) begin
      h_count = '0;
      v_count = (v_count == 10'd524) ? 10'd0 : v_count + 10'd1;
    end else begin
      h_count = h_count + 11'd1;
    end
  endtask

  task automatic set_pos(input int v, input int h);
    v_count = 10'(v);
    h_count = 11'(h);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic count_pulses(input int n, output int pulses, output int at_h);
    pulses = 0;
    at_h   = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (rot_valid) begin
        pulses++;
        at_h = int'(h_count);
      end
    end
  endtask

  initial begin
    int pulses, at_h, guard;
    rst = 1'b1; run = 1'b0; line_ack = 1'b0;
    set_pos(0, 0);
    #1;

    // Reset values
    do_reset();
    check_eq("rst_line_req", line_req, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_frame_cnt", frame_cnt, 0);
    check_eq("rst_cos_a", cos_a, 16384);
    check_eq("rst_sin_a", sin_a, 0);
    check_eq("rst_rot_valid", rot_valid, 0);

    // One rotation step with run=1
    run = 1'b1;
    set_pos(480, 0);
    count_pulses(4, pulses, at_h);
    check_eq("rot_no_early_pulse", pulses, 0);
    check_eq("rot_sin_a_stable", sin_a, 0);
    count_pulses(6, pulses, at_h);
    check_eq("rot_pulse_count", pulses, 1);
    check_eq("rot_pulse_at_h", at_h, 5);
    check_eq("rot_cos_a", cos_a, 16384);
    check_eq("rot_sin_a", sin_a, 512);
    check_eq("rot_cos_b", cos_b, 16384);
    check_eq("rot_sin_b", sin_b, 256);
    check_eq("rot_frame_cnt", frame_cnt, 1);

    // Line request acknowledged at h=1223
    run = 1'b0;
    set_pos(0, 1220);
    tick();
    check_eq("lreq_req", line_req, 1);
    check_eq("lreq_y", line_y, 1);
    tick();
    tick();
    check_eq("lreq_y_held", line_y, 1);
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
    check_eq("lreq_h_after_ack", h_count, 1224);
    check_eq("lreq_dropped", line_req, 0);
    check_eq("lreq_no_overrun", overrun, 0);

    // Ack coincident with the deadline counts as success
    set_pos(3, 1220);
    tick();
    check_eq("dl_ack_req", line_req, 1);
    set_pos(3, 1524);
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
    check_eq("dl_ack_req_low", line_req, 0);
    check_eq("dl_ack_no_overrun", overrun, 0);

    // No ack: request held until h=1524, then overrun
    set_pos(1, 1220);
    tick();
    check_eq("to_y", line_y, 2);
    guard = 0;
    while (h_count != 11'd1524 && guard < 400) begin
      tick();
      guard++;
    end
    check_eq("to_reached_deadline", h_count, 1524);
    check_eq("to_req_at_deadline", line_req, 1);
    tick();
    check_eq("to_req_low", line_req, 0);
    check_eq("to_overrun", overrun, 1);
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
    tick();
    check_eq("to_overrun_sticky", overrun, 1);
    check_eq("to_stray_ack_req", line_req, 0);

    // Line boundaries and frozen frame
    do_reset();
    check_eq("rst2_overrun", overrun, 0);
    set_pos(479, 1220);
    tick();
    check_eq("v479_no_req", line_req, 0);
    set_pos(524, 1220);
    tick();
    check_eq("v524_req", line_req, 1);
    check_eq("v524_y", line_y, 0);
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
    check_eq("v524_acked", line_req, 0);
    set_pos(480, 0);
    count_pulses(10, pulses, at_h);
    check_eq("frz_pulses", pulses, 0);
    check_eq("frz_frame_cnt", frame_cnt, 1);
    check_eq("frz_sin_a", sin_a, 0);
    check_eq("frz_sin_b", sin_b, 0);

    // Line event while rotating is dropped and flags overrun
    run = 1'b1;
    set_pos(480, 0);
    tick();
    set_pos(5, 1220);
    tick();
    check_eq("busy_no_req", line_req, 0);
    check_eq("busy_overrun", overrun, 1);
    count_pulses(6, pulses, at_h);
    check_eq("busy_rot_done", pulses, 1);

    // Reset during a request and during S_ROT_B1
    do_reset();
    set_pos(10, 1220);
    tick();
    check_eq("rreq_req", line_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rreq_req_low", line_req, 0);
    check_eq("rreq_y", line_y, 0);
    set_pos(480, 0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_pulses(10, pulses, at_h);
    check_eq("rrot_pulses", pulses, 0);
    check_eq("rrot_cos_a", cos_a, 16384);
    check_eq("rrot_sin_a", sin_a, 0);
    check_eq("rrot_cos_b", cos_b, 16384);
    check_eq("rrot_sin_b", sin_b, 0);
    check_eq("rrot_frame_cnt", frame_cnt, 0);

    // frame_cnt wraps at 255
    run = 1'b0;
    for (int i = 0; i < 255; i++) begin
      set_pos(480, 0);
      tick();
    end
    check_eq("fc_255", frame_cnt, 255);
    set_pos(480, 0);
    tick();
    check_eq("fc_wrap", frame_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
